// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: packet-level round-robin arbiter sharing one
// NoC injection port; grant is held from header flit to tail flit.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = `Noc_Data_Width,
    parameter int CNT_W   = 16
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_flit,
    input  logic [NUM_REQ-1:0]        req_is_header,
    input  logic [NUM_REQ-1:0]        req_is_tail,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_flit,
    output logic                      out_is_header,
    output logic                      out_is_tail,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic [NUM_REQ-1:0]        err_flags,
    input  logic                      err_clear,
    output logic [CNT_W-1:0]          pkt_cnt
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, state_n;
    logic [2:0]         rr_ptr, rr_n, grant_n;
    logic               first, first_n;
    logic [NUM_REQ-1:0] err_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [NUM_REQ-1:0] cand, stray;
    logic               g_valid;
    logic               found;
    logic               xfer;

    assign cand  = req_valid & req_is_header;
    assign stray = req_valid & ~req_is_header;
    assign busy  = (state == LOCKED);

    // Select the granted requester's lane; flit and flags always follow it.
    always_comb begin
        g_valid       = 1'b0;
        out_flit      = '0;
        out_is_header = 1'b0;
        out_is_tail   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(grant_id)) begin
                g_valid       = req_valid[i];
                out_flit      = req_flit[i*DATA_W +: DATA_W];
                out_is_header = req_is_header[i];
                out_is_tail   = req_is_tail[i];
            end
        end
    end

    // Next-state, arbitration, handshake and error/counter updates.
    always_comb begin
        state_n   = state;
        grant_n   = grant_id;
        rr_n      = rr_ptr;
        first_n   = first;
        err_n     = err_flags;
        cnt_n     = pkt_cnt;
        req_ready = '0;
        out_valid = 1'b0;
        found     = 1'b0;
        xfer      = 1'b0;
        unique case (state)
            IDLE: begin
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (cand[i] && i >= int'(rr_ptr)) begin
                        found   = 1'b1;
                        grant_n = 3'(i);
                    end
                end
                if (!found) begin
                    for (int i = NUM_REQ - 1; i >= 0; i--) begin
                        if (cand[i]) begin
                            found   = 1'b1;
                            grant_n = 3'(i);
                        end
                    end
                end
                if (found) begin
                    state_n = LOCKED;
                    first_n = 1'b1;
                end
                req_ready = stray;
                err_n     = err_flags | stray;
            end
            LOCKED: begin
                out_valid = g_valid;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == int'(grant_id)) req_ready[i] = out_ready;
                end
                xfer = g_valid & out_ready;
                if (xfer) begin
                    first_n = 1'b0;
                    if (out_is_header && !first) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (i == int'(grant_id)) err_n[i] = 1'b1;
                        end
                    end
                    if (out_is_tail) begin
                        state_n = IDLE;
                        rr_n    = (int'(grant_id) == NUM_REQ - 1) ?
                                  3'd0 : grant_id + 3'd1;
                        cnt_n   = pkt_cnt + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
        if (err_clear) err_n = '0;
        if (!noc_rst_n) begin
            req_ready = '0;
            out_valid = 1'b0;
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 3'd0;
            grant_id  <= 3'd0;
            first     <= 1'b0;
            err_flags <= '0;
            pkt_cnt   <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            grant_id  <= grant_n;
            first     <= first_n;
            err_flags <= err_n;
            pkt_cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb_noc_inject_arbiter: vector table, directed corner sequences and
// randomized traffic against a packet-rule reference model.
module tb_noc_inject_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int CW = 16;

    logic          noc_clk = 1'b0;
    logic          noc_rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*DW-1:0] req_flit = '0;
    logic [N-1:0]  req_is_header = '0;
    logic [N-1:0]  req_is_tail = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_flit;
    logic          out_is_header;
    logic          out_is_tail;
    logic [2:0]    grant_id;
    logic          busy;
    logic [N-1:0]  err_flags;
    logic          err_clear = 1'b0;
    logic [CW-1:0] pkt_cnt;

    int n_chk = 0;
    int n_fail = 0;

    noc_inject_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_flit(req_flit), .req_is_header(req_is_header),
        .req_is_tail(req_is_tail), .out_valid(out_valid),
        .out_ready(out_ready), .out_flit(out_flit),
        .out_is_header(out_is_header), .out_is_tail(out_is_tail),
        .grant_id(grant_id), .busy(busy), .err_flags(err_flags),
        .err_clear(err_clear), .pkt_cnt(pkt_cnt)
    );

    always #5 noc_clk = ~noc_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  v, h, t;
        logic        ordy, eclr;
        logic [15:0] base;
        logic [3:0]  e_rdy;
        logic        e_ov, e_busy;
        logic [2:0]  e_gid;
        logic [3:0]  e_err;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic [3:0] v, h, t, input logic ordy, eclr,
        input logic [15:0] base, input logic [3:0] rdy,
        input logic ov, bz, input logic [2:0] gid,
        input logic [3:0] err, input logic [15:0] cnt);
        vec_t r;
        r.v = v; r.h = h; r.t = t; r.ordy = ordy; r.eclr = eclr;
        r.base = base; r.e_rdy = rdy; r.e_ov = ov; r.e_busy = bz;
        r.e_gid = gid; r.e_err = err; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic set_lanes(input logic [3:0] v, h, t,
                             input logic [15:0] base);
        req_valid = v;
        req_is_header = h;
        req_is_tail = t;
        for (int i = 0; i < N; i++) req_flit[i*DW +: DW] = base + 16'(i);
    endtask

    task automatic reset_dut();
        @(negedge noc_clk);
        noc_rst_n = 1'b0;
        set_lanes(4'h0, 4'h0, 4'h0, 16'h0);
        err_clear = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge noc_clk);
        noc_rst_n = 1'b1;
    endtask

    vec_t tbl[19];

    bit          m_lock, m_first;
    int          m_gid, m_rr, g, nx, last_h;
    logic [3:0]  m_err, e_rdy, rdy_s;
    logic [15:0] m_cnt;
    logic        e_ov;
    int          ph[N];
    int          order[$];
    bit          done;

    initial begin
        tbl[0]  = mk(4'h0, 4'h0, 4'h0, 1, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 0);
        tbl[1]  = mk(4'h1, 4'h1, 4'h0, 1, 0, 16'hA000, 4'h0, 0, 0, 0, 4'h0, 0);
        tbl[2]  = mk(4'h1, 4'h1, 4'h0, 1, 0, 16'hA000, 4'h1, 1, 1, 0, 4'h0, 0);
        tbl[3]  = mk(4'h1, 4'h0, 4'h0, 1, 0, 16'hFFFF, 4'h1, 1, 1, 0, 4'h0, 0);
        tbl[4]  = mk(4'h1, 4'h0, 4'h1, 1, 0, 16'h00C0, 4'h1, 1, 1, 0, 4'h0, 0);
        tbl[5]  = mk(4'h0, 4'h0, 4'h0, 1, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 1);
        tbl[6]  = mk(4'h2, 4'h0, 4'h0, 1, 0, 16'h1100, 4'h2, 0, 0, 0, 4'h0, 1);
        tbl[7]  = mk(4'h0, 4'h0, 4'h0, 1, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h2, 1);
        tbl[8]  = mk(4'h0, 4'h0, 4'h0, 1, 1, 16'h0000, 4'h0, 0, 0, 0, 4'h2, 1);
        tbl[9]  = mk(4'h0, 4'h0, 4'h0, 1, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 1);
        tbl[10] = mk(4'h5, 4'h5, 4'h0, 1, 0, 16'hB000, 4'h0, 0, 0, 0, 4'h0, 1);
        tbl[11] = mk(4'h5, 4'h5, 4'h0, 1, 0, 16'hB000, 4'h4, 1, 1, 2, 4'h0, 1);
        tbl[12] = mk(4'h5, 4'h1, 4'h0, 0, 0, 16'hC000, 4'h0, 1, 1, 2, 4'h0, 1);
        tbl[13] = mk(4'h5, 4'h1, 4'h0, 0, 0, 16'hC000, 4'h0, 1, 1, 2, 4'h0, 1);
        tbl[14] = mk(4'h5, 4'h1, 4'h0, 1, 0, 16'hC000, 4'h4, 1, 1, 2, 4'h0, 1);
        tbl[15] = mk(4'h5, 4'h1, 4'h4, 1, 0, 16'hD000, 4'h4, 1, 1, 2, 4'h0, 1);
        tbl[16] = mk(4'h1, 4'h1, 4'h0, 1, 0, 16'hE000, 4'h0, 0, 0, 2, 4'h0, 2);
        tbl[17] = mk(4'h1, 4'h1, 4'h1, 1, 0, 16'hE000, 4'h1, 1, 1, 0, 4'h0, 2);
        tbl[18] = mk(4'h0, 4'h0, 4'h0, 1, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 3);

        reset_dut();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_err", err_flags, 0);
        chk("rst_cnt", pkt_cnt, 0);
        for (int r = 0; r < 19; r++) begin
            @(negedge noc_clk);
            set_lanes(tbl[r].v, tbl[r].h, tbl[r].t, tbl[r].base);
            out_ready = tbl[r].ordy;
            err_clear = tbl[r].eclr;
            #2;
            chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_oval", r), out_valid, tbl[r].e_ov);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
            chk($sformatf("tbl%0d_gid", r), grant_id, tbl[r].e_gid);
            chk($sformatf("tbl%0d_err", r), err_flags, tbl[r].e_err);
            chk($sformatf("tbl%0d_cnt", r), pkt_cnt, tbl[r].e_cnt);
            if (tbl[r].e_ov)
                chk($sformatf("tbl%0d_flit", r), out_flit,
                    tbl[r].base + 16'(tbl[r].e_gid));
        end

        // fairness: all four hold 2-flit packets
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) ph[i] = 0;
        order.delete();
        last_h = -1;
        done = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge noc_clk);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = 1'b1;
                req_is_header[i] = (ph[i] == 0);
                req_is_tail[i] = (ph[i] == 1);
                req_flit[i*DW +: DW] = {4'(i), 11'd0, 1'(ph[i])};
            end
            #2;
            if (out_valid && out_ready) begin
                if (out_is_header) begin
                    order.push_back(int'(grant_id));
                    last_h = int'(grant_id);
                end else begin
                    chk("fair_contig", 32'(grant_id), last_h);
                end
                chk("fair_lane", out_flit[15:12], grant_id);
            end
            rdy_s = req_ready;
            if (pkt_cnt == 16'd8) done = 1;
            for (int i = 0; i < N; i++) if (rdy_s[i]) ph[i] = 1 - ph[i];
        end
        chk("fair_done", done, 1);
        chk("fair_cnt", pkt_cnt, 8);
        chk("fair_npkt", order.size(), 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("fair_order%0d", k),
                (k < order.size()) ? order[k] : -1, k % 4);

        // single-flit packets from req3 back-to-back
        reset_dut();
        set_lanes(4'h8, 4'h8, 4'h8, 16'h3330);
        out_ready = 1'b1;
        nx = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            chk($sformatf("sf_oval%0d", c), out_valid, c % 2);
            if (out_valid && out_ready) begin
                nx++;
                chk("sf_ht", {out_is_header, out_is_tail}, 2'b11);
                chk("sf_flit", out_flit, 16'h3333);
            end
            @(negedge noc_clk);
        end
        #2;
        chk("sf_xfers", nx, 5);
        chk("sf_cnt", pkt_cnt, 5);

        // reset in the middle of req0's packet
        reset_dut();
        out_ready = 1'b1;
        set_lanes(4'h4, 4'h4, 4'h4, 16'h5000);
        repeat (2) @(negedge noc_clk);
        set_lanes(4'h1, 4'h1, 4'h0, 16'h6000);
        repeat (2) @(negedge noc_clk);
        set_lanes(4'hB, 4'hA, 4'h0, 16'h7000);
        #2;
        chk("mid_pre_busy", busy, 1);
        chk("mid_pre_ready", req_ready, 4'h1);
        noc_rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_oval", out_valid, 0);
        chk("mid_ready", req_ready, 4'h0);
        chk("mid_gid", grant_id, 0);
        @(negedge noc_clk);
        set_lanes(4'hA, 4'hA, 4'h0, 16'h8000);
        noc_rst_n = 1'b1;
        #2;
        chk("rel_busy", busy, 0);
        chk("rel_oval", out_valid, 0);
        @(negedge noc_clk);
        #2;
        chk("rel_gbusy", busy, 1);
        chk("rel_gid", grant_id, 1);
        chk("rel_ready", req_ready, 4'h2);
        chk("rel_flit", out_flit, 16'h8001);
        chk("rel_cnt", pkt_cnt, 0);

        // randomized traffic against the reference model
        reset_dut();
        m_lock = 0; m_first = 0; m_gid = 0; m_rr = 0;
        m_err = '0; m_cnt = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge noc_clk);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 7);
                req_is_header[i] = ($urandom_range(0, 9) < 3);
                req_is_tail[i] = ($urandom_range(0, 9) < 3);
                req_flit[i*DW +: DW] = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            err_clear = ($urandom_range(0, 31) == 0);
            #2;
            g = m_gid;
            if (m_lock) e_rdy = out_ready ? 4'(1 << g) : 4'h0;
            else e_rdy = req_valid & ~req_is_header;
            e_ov = m_lock && req_valid[g];
            chk("rnd_ready", req_ready, e_rdy);
            chk("rnd_oval", out_valid, e_ov);
            chk("rnd_busy", busy, m_lock);
            chk("rnd_gid", grant_id, m_gid);
            chk("rnd_err", err_flags, m_err);
            chk("rnd_cnt", pkt_cnt, m_cnt);
            chk("rnd_flit", out_flit, req_flit[g*DW +: DW]);
            chk("rnd_flags", {out_is_header, out_is_tail},
                {req_is_header[g], req_is_tail[g]});
            if (!m_lock) begin
                m_err = m_err | (req_valid & ~req_is_header);
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_rr + k) % N;
                    if (!m_lock && req_valid[idx] && req_is_header[idx]) begin
                        m_lock = 1;
                        m_first = 1;
                        m_gid = idx;
                    end
                end
            end else if (req_valid[g] && out_ready) begin
                if (req_is_header[g] && !m_first) m_err[g] = 1'b1;
                m_first = 0;
                if (req_is_tail[g]) begin
                    m_lock = 0;
                    m_rr = (g + 1) % N;
                    m_cnt = m_cnt + 16'd1;
                end
            end
            if (err_clear) m_err = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Packet-level round-robin arbiter that shares one NoC node injection port among NUM_REQ local requesters (traffic generators, AXI bridges).
- Grant is locked from header flit until the tail flit is accepted, so packets from different requesters never interleave on the router input.
- Sits between local sources and the router's local-port receiver.
- Provides sticky per-requester protocol-error flags and a packet counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, `Noc_Data_Width, flit width.
- CNT_W, 16, width of the sent-packet counter.

Ports:
- noc_clk  in  1  clock
- noc_rst_n  in  1  async active-low reset
- req_valid  in  NUM_REQ  per-requester flit valid
- req_ready  out  NUM_REQ  per-requester flit accept
- req_flit  in  NUM_REQ*DATA_W  flits; requester i occupies bits [i*DATA_W +: DATA_W]
- req_is_header  in  NUM_REQ  flit is header
- req_is_tail  in  NUM_REQ  flit is tail
- out_valid  out  1  to router local port
- out_ready  in  1  from router
- out_flit  out  DATA_W  muxed flit
- out_is_header  out  1  muxed header flag
- out_is_tail  out  1  muxed tail flag
- grant_id  out  3  current or last granted requester
- busy  out  1  grant locked
- err_flags  out  NUM_REQ  sticky protocol error per requester
- err_clear  in  1  clears err_flags
- pkt_cnt  out  CNT_W  packets fully sent (tail accepted)

Behaviour:
- Reset, async on noc_rst_n low, applies immediately including mid-packet:
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0, err_flags=0, pkt_cnt=0.
  - out_valid=0, req_ready=0; out_flit, out_is_header and out_is_tail follow the muxed inputs.
  - A packet interrupted by reset is abandoned; no tail is synthesised.
- Transfer means valid&ready on the same cycle.

States:
- IDLE (busy=0, out_valid=0):
  - Candidates are requesters with req_valid&req_is_header.
  - If any candidate exists, select the first at or after rr_ptr (cyclic). Register it in grant_id and go to LOCKED next cycle. Arbitration latency is 1 cycle; no flit is transferred in the IDLE cycle.
  - Requesters with req_valid&!req_is_header get req_ready=1, so the stray flit is dropped, and set err_flags[i].
  - Header-valid requesters get req_ready=0.
- LOCKED (busy=1):
  - out_valid, out_flit, out_is_header and out_is_tail are the combinational mux of requester grant_id.
  - req_ready[grant_id]=out_ready; all other req_ready=0.
  - Transfer with is_tail: next state IDLE, rr_ptr=(grant_id+1) mod NUM_REQ, pkt_cnt+1 (wraps at 2^CNT_W).
  - Single-flit packet (header&tail) takes one LOCKED cycle.
  - Transfer of a header flit that is not the first flit of the locked packet: the flit is forwarded and err_flags[grant_id] is set.
  - Granted requester deasserting valid mid-packet: out_valid=0, grant held, no timeout.
- err_clear has priority over setting in the same cycle: the flags clear and the new error is lost.
- The output path is combinational from req_* and out_ready when LOCKED; the pipeline register lives in the router input buffer.
- After IDLE→LOCKED→IDLE, at least one IDLE cycle separates packets. Maximum throughput is (L)/(L+1) for packets of L flits.

Test Plan:
- Single requester:
  - Stimulus: req0 sends 3-flit packet (header 0xA0.., data all-ones, tail), out_ready=1.
  - Required: grant_id=0 after 1 cycle; 3 consecutive out transfers in order; busy falls after the tail; pkt_cnt=1.
- Fairness:
  - Stimulus: req0..req3 all hold 2-flit packets continuously.
  - Required: grant order is 0,1,2,3,0 and so on; each packet is contiguous on out; pkt_cnt=8 after 8 packets.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 during a req2 3-flit packet.
  - Required: flits are not duplicated or lost; req_ready[2] mirrors out_ready; other requesters are not granted until the tail.
- Stray flit:
  - Stimulus: req1 presents valid with no header while IDLE.
  - Required: req_ready[1]=1 that cycle; err_flags=4'b0010; out_valid=0; err_clear pulse returns err_flags to 0.
- Single-flit packets:
  - Stimulus: req3 sends 5 header+tail flits back-to-back.
  - Required: out alternates IDLE/LOCKED; 5 transfers with out_is_header=out_is_tail=1; pkt_cnt=5.
- Reset mid-packet:
  - Stimulus: assert noc_rst_n=0 after the header of req0's packet.
  - Required: busy=0, out_valid=0 and req_ready=0 immediately. After release, req1's header is granted normally with rr_ptr=0.
